div_unit: RTL and testbench
===========================

# div_unit

Multi-cycle 32-bit integer divider used by the execute stage for DIV/DIVU, consuming the ALU operation and operands that the decode/execute pipeline register delivers. It runs a radix-2 restoring division over 32 iterations and returns {remainder, quotient} for writing into HI/LO. A registered ready/busy handshake lets EX hold the pipeline until the result is available.

## Interface
- No parameters; datapath width is fixed at 32 bits (`RegBus`).
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high (`RstEnable`).
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
- opdata1_i  input  32  dividend; sampled with start.
- opdata2_i  input  32  divisor; sampled with start.
- start_i  input  1  request; EX holds it high until it has consumed ready_o.
- annul_i  input  1  abort the operation in flight (pipeline flush).
- result_o  output  64  {remainder[63:32], quotient[31:0]}; registered.
- ready_o  output  1  result_o valid; registered.
- busy_o  output  1  state ≠ FREE; decoded from the state register only (no input-to-output path).

## Operation
- States: FREE, BY_ZERO, ON, END (2-bit state register).
- FREE: if start_i=1 and annul_i=0, latch signed_div_i and operands. Divisor 0 → BY_ZERO. Otherwise → ON with cnt=0.
  - In signed mode, latch |opdata1| and |opdata2|. In unsigned mode, latch the raw values.
  - start_i=1 together with annul_i=1 is ignored; the unit stays in FREE.
- BY_ZERO: next edge → END with result_o=0.
- ON, annul_i=1: next edge → FREE, result_o=0, ready_o=0. No partial result leaks out.
- ON, annul_i=0: one restoring step per edge.
  - The working register is 65 bits: {partial remainder, dividend/quotient}.
  - Compute diff = upper 33 bits − {1'b0, divisor}.
  - diff negative: shift left by 1 and insert quotient bit 0.
  - Otherwise: load diff[31:0] into the upper half, shift, and insert quotient bit 1.
  - cnt increments on each step (6-bit).
- ON with cnt=32: apply the sign fix and go to END.
  - Signed mode: negate the quotient if the operand signs differ. The remainder takes the sign of the dividend.
  - Unsigned mode: no correction.
  - Load result_o and set ready_o=1.
- END: hold result_o and ready_o=1 while start_i=1. When start_i=0, next edge → FREE with result_o=0 and ready_o=0.
- Input changes after the start edge (start_i, operands, signed_div_i) are ignored until the unit returns to FREE.
- annul_i has no effect in BY_ZERO or END.
- Signed 0x80000000 / 0xFFFFFFFF: magnitudes are 2^31 and 1, so quotient = 0x80000000 and remainder = 0. No trap; the result is deterministic.
- Reset, including mid-operation: state=FREE, cnt=0, result_o=0, ready_o=0, busy_o=0.

## Timing
- E0 = the edge that samples start_i=1 in FREE. busy_o goes high after E0.
- Normal division:
  - Iterations occur at E1..E32; the sign fix and END happen at E33.
  - ready_o is high after E33, giving 33-cycle latency.
  - EX stall request = start_i & ~ready_o, formed in EX.
- Divide by zero: BY_ZERO after E0, END at E1, ready_o high after E1.
- Back-to-back operations need at least one cycle with start_i=0 so END can return to FREE. Minimum issue interval is 35 cycles.
- All outputs are registered. busy_o is a pure state decode.

## Test plan
- Unsigned 100 / 7: start held → ready_o rises exactly 33 edges after E0, result_o = {32'd2, 32'd14}. Drop start → next edge ready_o=0, result_o=0.
- Signed −7 / 2 (0xFFFFFFF9, 0x2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also 7 / −2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero: 0x12345678 / 0 → ready_o after E1, result_o=0. Then 0x80000000 / 0xFFFFFFFF signed → quotient 0x80000000, remainder 0.
- Annul: 0xFFFFFFFF / 1 unsigned, assert annul_i for one cycle at E10 → FREE next edge with busy_o=0, ready_o never rises. Restart with 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- Reset mid-op: rst at E20 → all outputs 0 after that edge. Operand changes during ON do not alter the result (random 32-bit pairs checked against a reference model).

Source files
------------

// File: rtl/div_unit.sv
// Multi-cycle 32-bit radix-2 restoring divider for DIV/DIVU.
// Returns {remainder, quotient} with a registered ready/busy handshake.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        FREE    = 2'b00,
        BY_ZERO = 2'b01,
        ON      = 2'b10,
        END     = 2'b11
    } state_t;

    state_t      state, state_next;
    logic [5:0]  cnt, cnt_next;
    logic [64:0] work, work_next;
    logic [31:0] divisor, divisor_next;
    logic        neg_quot, neg_quot_next;
    logic        neg_rem, neg_rem_next;
    logic [63:0] result_next;
    logic        ready_next;

    logic [32:0] diff;
    logic [31:0] abs1, abs2;
    logic [31:0] quot, rem;

    // Remainder lives in work[64:33]; work[64:32] is that remainder with the next dividend bit appended.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        work_next     = work;
        divisor_next  = divisor;
        neg_quot_next = neg_quot;
        neg_rem_next  = neg_rem;
        result_next   = result_o;
        ready_next    = ready_o;

        diff = work[64:32] - {1'b0, divisor};
        quot = work[31:0];
        rem  = work[64:33];
        abs1 = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
        abs2 = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;

        case (state)
            FREE: begin
                if (start_i && !annul_i) begin
                    neg_quot_next = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                    neg_rem_next  = signed_div_i & opdata1_i[31];
                    divisor_next  = abs2;
                    work_next     = {32'd0, abs1, 1'b0};
                    cnt_next      = 6'd0;
                    state_next    = (opdata2_i == 32'd0) ? BY_ZERO : ON;
                end
            end
            BY_ZERO: begin
                state_next  = END;
                result_next = 64'd0;
                ready_next  = 1'b1;
            end
            ON: begin
                if (annul_i) begin
                    state_next  = FREE;
                    cnt_next    = 6'd0;
                    result_next = 64'd0;
                    ready_next  = 1'b0;
                end else if (cnt == 6'd32) begin
                    state_next  = END;
                    result_next = {(neg_rem ? -rem : rem), (neg_quot ? -quot : quot)};
                    ready_next  = 1'b1;
                end else begin
                    if (diff[32])
                        work_next = {work[63:0], 1'b0};
                    else
                        work_next = {diff[31:0], work[31:0], 1'b1};
                    cnt_next = cnt + 6'd1;
                end
            end
            END: begin
                if (!start_i) begin
                    state_next  = FREE;
                    result_next = 64'd0;
                    ready_next  = 1'b0;
                end
            end
            default: state_next = FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FREE;
            cnt      <= 6'd0;
            work     <= 65'd0;
            divisor  <= 32'd0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            work     <= work_next;
            divisor  <= divisor_next;
            neg_quot <= neg_quot_next;
            neg_rem  <= neg_rem_next;
            result_o <= result_next;
            ready_o  <= ready_next;
        end
    end

    assign busy_o = (state != FREE);

endmodule

// File: tb/tb_div_unit.sv
// Randomized self-checking bench for div_unit against a transaction-level reference model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int tests = 0;
    int fails = 0;

    div_unit dut (
        .clk         (clk),
        .rst         (rst),
        .signed_div_i(signed_div_i),
        .opdata1_i   (opdata1_i),
        .opdata2_i   (opdata2_i),
        .start_i     (start_i),
        .annul_i     (annul_i),
        .result_o    (result_o),
        .ready_o     (ready_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    // Reference quotient/remainder using 64-bit integer arithmetic (truncating division).
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, q, r;
        logic [63:0] qv, rv;
        if (b == 32'd0) return 64'd0;
        sa = s ? longint'($signed(a)) : longint'({32'd0, a});
        sb = s ? longint'($signed(b)) : longint'({32'd0, b});
        q  = sa / sb;
        r  = sa % sb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Cycle-level expectation: busy from start to release, ready after fixed latency.
    logic        m_valid = 1'b0;
    logic        m_busy, m_ready, m_zero;
    logic [63:0] m_result, m_pending;
    int          m_left;

    always @(posedge clk) begin
        if (rst) begin
            m_valid  <= 1'b1;
            m_busy   <= 1'b0;
            m_ready  <= 1'b0;
            m_zero   <= 1'b0;
            m_result <= 64'd0;
            m_left   <= 0;
        end else if (m_valid) begin
            if (!m_busy) begin
                if (start_i && !annul_i) begin
                    m_busy    <= 1'b1;
                    m_zero    <= (opdata2_i == 32'd0);
                    m_pending <= ref_div(opdata1_i, opdata2_i, signed_div_i);
                    m_left    <= (opdata2_i == 32'd0) ? 1 : 33;
                end
            end else if (m_ready) begin
                if (!start_i) begin
                    m_busy   <= 1'b0;
                    m_ready  <= 1'b0;
                    m_result <= 64'd0;
                end
            end else if (annul_i && !m_zero) begin
                m_busy   <= 1'b0;
                m_result <= 64'd0;
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_ready  <= 1'b1;
                    m_result <= m_pending;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("busy_o", {63'd0, busy_o}, {63'd0, m_busy});
            checkOutput("ready_o", {63'd0, ready_o}, {63'd0, m_ready});
            checkOutput("result_o", result_o, m_result);
        end
    end

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 input logic hold_annul, output int lat, output logic [63:0] res);
        @(negedge clk);
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = s;
        start_i      = 1'b1;
        lat          = -1;
        res          = 64'd0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = 1'($urandom);
            annul_i      = hold_annul;
            if (ready_o) begin
                lat = i;
                res = result_o;
                break;
            end
        end
        start_i = 1'b0;
        annul_i = 1'b0;
        @(negedge clk);
        checkOutput("drop ready", {63'd0, ready_o}, 64'd0);
        checkOutput("drop result", result_o, 64'd0);
    endtask

    initial begin
        int          lat;
        logic [63:0] res;
        logic [31:0] a, b;
        logic        s, seen;

        rst          = 1'b1;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", {63'd0, busy_o}, 64'd0);
        checkOutput("reset ready", {63'd0, ready_o}, 64'd0);
        checkOutput("reset result", result_o, 64'd0);
        rst = 1'b0;

        checkOutput("model 100/7", ref_div(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
        checkOutput("model -7/2", ref_div(32'hFFFFFFF9, 32'd2, 1'b1), {32'hFFFFFFFF, 32'hFFFFFFFD});
        checkOutput("model 7/-2", ref_div(32'd7, 32'hFFFFFFFE, 1'b1), {32'h00000001, 32'hFFFFFFFD});
        checkOutput("model min/-1", ref_div(32'h80000000, 32'hFFFFFFFF, 1'b1), {32'd0, 32'h80000000});

        applyStimulus(32'd100, 32'd7, 1'b0, 1'b0, lat, res);
        checkOutput("100/7 latency", 64'(lat), 64'd33);
        checkOutput("100/7 result", res, {32'd2, 32'd14});

        applyStimulus(32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, lat, res);
        checkOutput("-7/2 result", res, {32'hFFFFFFFF, 32'hFFFFFFFD});
        applyStimulus(32'd7, 32'hFFFFFFFE, 1'b1, 1'b0, lat, res);
        checkOutput("7/-2 result", res, {32'h00000001, 32'hFFFFFFFD});

        applyStimulus(32'h12345678, 32'd0, 1'b0, 1'b0, lat, res);
        checkOutput("div0 latency", 64'(lat), 64'd1);
        checkOutput("div0 result", res, 64'd0);
        applyStimulus(32'h87654321, 32'd0, 1'b1, 1'b1, lat, res);
        checkOutput("div0 annul latency", 64'(lat), 64'd1);
        applyStimulus(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, lat, res);
        checkOutput("min/-1 result", res, {32'd0, 32'h80000000});

        @(negedge clk);
        opdata1_i    = 32'hFFFFFFFF;
        opdata2_i    = 32'd1;
        signed_div_i = 1'b0;
        start_i      = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("annul pre busy", {63'd0, busy_o}, 64'd1);
        start_i = 1'b0;
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        checkOutput("annul busy", {63'd0, busy_o}, 64'd0);
        checkOutput("annul ready", {63'd0, ready_o}, 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) seen = 1'b1;
        end
        checkOutput("annul no ready", {63'd0, seen}, 64'd0);
        applyStimulus(32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, lat, res);
        checkOutput("restart result", res, {32'd0, 32'hFFFFFFFF});

        @(negedge clk);
        opdata1_i = 32'hDEADBEEF;
        opdata2_i = 32'd3;
        start_i   = 1'b1;
        repeat (20) @(negedge clk);
        rst     = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        checkOutput("midrst busy", {63'd0, busy_o}, 64'd0);
        checkOutput("midrst ready", {63'd0, ready_o}, 64'd0);
        checkOutput("midrst result", result_o, 64'd0);
        rst = 1'b0;

        for (int n = 0; n < 150; n++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) a = 32'h80000000;
            s = 1'($urandom);
            applyStimulus(a, b, s, 1'b0, lat, res);
            checkOutput("rand latency", 64'(lat), (b == 32'd0) ? 64'd1 : 64'd33);
            checkOutput("rand result", res, ref_div(a, b, s));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
